// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier slice.
package booth_pkg;

    localparam int WIDTH = 4;
    localparam int STEPS = 4;
    localparam int ACCW  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/booth_addsub5.sv
// Stateless 5-bit adder/subtractor used for the Booth accumulate step.
import booth_pkg::*;

module booth_addsub5 (
    input  logic            M,
    input  logic [ACCW-1:0] X,
    input  logic [ACCW-1:0] Y,
    output logic [ACCW-1:0] S
);

    // Carry-out is dropped on purpose; the accumulator wraps at ACCW bits.
    always_comb begin
        if (M) S = X - Y;
        else   S = X + Y;
    end

endmodule

// File: rtl/booth_mult_4bits.sv
// Sequential radix-2 Booth multiplier: 4x4 signed operands, 8-bit signed product.
import booth_pkg::*;

module booth_mult_4bits (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [7:0]       P
);

    state_t           state;
    logic [ACCW-1:0]  mreg;
    logic [ACCW-1:0]  acc;
    logic [WIDTH-1:0] q;
    logic             qm1;
    logic [2:0]       cnt;
    logic [ACCW-1:0]  sum;
    logic [ACCW-1:0]  step;

    booth_addsub5 u_addsub (
        .M (q[0]),
        .X (acc),
        .Y (mreg),
        .S (sum)
    );

    // Pair 01 adds, 10 subtracts; equal bits keep the accumulator as is.
    always_comb begin
        step = acc;
        if (q[0] ^ qm1) step = sum;
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            mreg  <= '0;
            acc   <= '0;
            q     <= '0;
            qm1   <= 1'b0;
            cnt   <= '0;
            P     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mreg  <= {A[WIDTH-1], A};
                        q     <= B;
                        acc   <= '0;
                        qm1   <= 1'b0;
                        cnt   <= 3'(STEPS);
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= {step[ACCW-1], step[ACCW-1:1]};
                    q   <= {step[0], q[WIDTH-1:1]};
                    qm1 <= q[0];
                    cnt <= cnt - 3'd1;
                    // Product equals the shifted {acc[3:0], q} of this final step.
                    if (cnt == 3'd1) begin
                        P     <= {step, q[WIDTH-1:1]};
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_4bits.sv
// Directed self-checking bench for booth_mult_4bits.
module tb_booth_mult_4bits;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic       busy;
    logic       done;
    logic [7:0] P;

    int checks;
    int errors;

    booth_mult_4bits dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .P     (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; A = 4'h0; B = 4'h0;
        @(negedge clk); @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || P !== 8'h00) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b P=%h, want busy=0 done=0 P=00", busy, done, P);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    // Start on a negedge, scramble operands during CALC, check 4 busy cycles,
    // a one-cycle done with the product, then P held in IDLE.
    task automatic test_mult(input logic [3:0] a, input logic [3:0] b,
                             input logic [7:0] exp, input string name);
        A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; A = ~a; B = ~b;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s_busy%0d: busy=%b done=%b, want 1 0", name, i, busy, done);
            end
            if (i == 3) start = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || P !== exp) begin
            errors++;
            $display("FAIL %s_done: busy=%b done=%b P=%h, want 0 1 %h", name, busy, done, P, exp);
        end
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || P !== exp) begin
            errors++;
            $display("FAIL %s_hold: busy=%b done=%b P=%h, want 0 0 %h", name, busy, done, P, exp);
        end
    endtask

    task automatic test_start_during_calc();
        int busy_cnt;
        busy_cnt = 0;
        A = 4'd3; B = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (busy === 1'b1) busy_cnt++;
        @(negedge clk);
        if (busy === 1'b1) busy_cnt++;
        A = 4'd5; B = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
        end
        checks++;
        if (busy_cnt != 4 || done !== 1'b1 || P !== 8'h06) begin
            errors++;
            $display("FAIL ignore_start: busy_cycles=%0d done=%b P=%h, want 4 1 06", busy_cnt, done, P);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_idle: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid_calc();
        A = 4'd7; B = 4'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || P !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_calc: busy=%b done=%b P=%h, want 0 0 00", busy, done, P);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || P !== 8'h00) begin
            errors++;
            $display("FAIL after_reset_mid_calc: busy=%b done=%b P=%h, want 0 0 00", busy, done, P);
        end
        test_mult(4'd2, 4'd3, 8'h06, "after_abort");
    endtask

    task automatic test_back_to_back();
        int n_done;
        int first_i;
        int second_i;
        n_done = 0; first_i = -1; second_i = -1;
        A = 4'hD; B = 4'd4; start = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 12) start = 1'b0;
            if (busy === 1'b1 && done === 1'b1) begin
                checks++; errors++;
                $display("FAIL b2b_overlap: busy=1 done=1 at cycle %0d, want never both", i);
            end
            if (done === 1'b1) begin
                n_done++;
                if (first_i < 0) first_i = i; else second_i = i;
                checks++;
                if (P !== 8'hF4) begin
                    errors++;
                    $display("FAIL b2b_product: P=%h at cycle %0d, want f4", P, i);
                end
            end
        end
        checks++;
        if (n_done != 2 || first_i != 5 || second_i != 11) begin
            errors++;
            $display("FAIL b2b_timing: dones=%0d at %0d,%0d, want 2 at 5,11", n_done, first_i, second_i);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mult(4'd7, 4'd6, 8'h2A, "mul_7x6");
        test_mult(4'h8, 4'h8, 8'h40, "mul_m8xm8");
        test_mult(4'd7, 4'h8, 8'hC8, "mul_7xm8");
        test_mult(4'hF, 4'hF, 8'h01, "mul_m1xm1");
        test_mult(4'd0, 4'd5, 8'h00, "mul_0x5");
        test_mult(4'h8, 4'd7, 8'hC8, "mul_m8x7");
        test_start_during_calc();
        test_reset_mid_calc();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded 100000 time units");
        $fatal(1);
    end

endmodule
